// File: rtl/axi_fifo64_to_fifo32_arb_pkg.sv
// Shared definitions for the 64-to-32 packet arbiter: FSM encoding, priority modes
// and a constant-width helper.
package axi_fifo64_to_fifo32_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HI   = 2'd1,
      ST_LO   = 2'd2
   } arb_state_e;

   localparam int PRIO_RR    = 0;
   localparam int PRIO_FIXED = 1;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/axi_fifo64_to_fifo32_arb_rr_pick.sv
// Combinational next-grant selection: round-robin starting at ptr_i, or fixed
// priority with index 0 highest.
module arb_rr_pick
   import axi_fifo64_to_fifo32_arb_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   parameter int PRIO      = PRIO_RR,
   parameter int SW        = clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] valid_i,
   input  logic [SW-1:0]        ptr_i,
   output logic [SW-1:0]        pick_o,
   output logic                 any_o
);

   int            idx;
   logic [SW-1:0] idx_s;

   // Scan from the farthest candidate down so the closest valid port wins.
   always_comb begin
      pick_o = '0;
      idx    = 0;
      idx_s  = '0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         idx   = (PRIO == PRIO_FIXED) ? k : (int'(ptr_i) + k) % NUM_PORTS;
         idx_s = SW'(idx);
         if (valid_i[idx_s]) pick_o = idx_s;
      end
   end

   assign any_o = |valid_i;

endmodule

// File: rtl/axi_fifo64_to_fifo32_arb.sv
// Packet-granular arbiter feeding NUM_PORTS 64-bit streams into one 32-bit stream,
// upper half first. Define AXI_ARB_PKT_CNT_EN to add per-port packet counters.
module axi_fifo64_to_fifo32_arb
   import axi_fifo64_to_fifo32_arb_pkg::*;
#(
   parameter  int NUM_PORTS = 4,
   parameter  int PRIO      = PRIO_RR,
   localparam int SW        = clog2(NUM_PORTS)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear,
   input  logic [64*NUM_PORTS-1:0] i_tdata,
   input  logic [3*NUM_PORTS-1:0]  i_tuser,
   input  logic [NUM_PORTS-1:0]    i_tlast,
   input  logic [NUM_PORTS-1:0]    i_tvalid,
   output logic [NUM_PORTS-1:0]    i_tready,
   output logic [31:0]             o_tdata,
   output logic [1:0]              o_tuser,
   output logic                    o_tlast,
   output logic                    o_tvalid,
   input  logic                    o_tready,
   output logic [SW-1:0]           o_src
`ifdef AXI_ARB_PKT_CNT_EN
   ,
   output logic [16*NUM_PORTS-1:0] pkt_cnt
`endif
);

   arb_state_e    state_q;
   logic [SW-1:0] grant_q, grant_d;
   logic [SW-1:0] rr_ptr_q, rr_ptr_d;
   logic          any_valid;

   logic [63:0]   data_a [NUM_PORTS];
   logic [2:0]    user_a [NUM_PORTS];
   logic [63:0]   g_data;
   logic [2:0]    g_user;
   logic          g_last, g_valid, g_short;
   logic          ready_sel, hs, last_acc;

   genvar gi;

   arb_rr_pick #(.NUM_PORTS(NUM_PORTS), .PRIO(PRIO), .SW(SW)) u_pick (
      .valid_i (i_tvalid),
      .ptr_i   (rr_ptr_q),
      .pick_o  (grant_d),
      .any_o   (any_valid)
   );

   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
         assign data_a[gi]   = i_tdata[64*gi +: 64];
         assign user_a[gi]   = i_tuser[3*gi +: 3];
         assign i_tready[gi] = ready_sel & (grant_q == SW'(gi));
      end
   endgenerate

   assign g_data  = data_a[grant_q];
   assign g_user  = user_a[grant_q];
   assign g_last  = i_tlast[grant_q];
   assign g_valid = i_tvalid[grant_q];
   // A last word carrying 1..4 bytes fits entirely in the upper half.
   assign g_short = g_last & (g_user != 3'd0) & (g_user <= 3'd4);

   always_comb begin
      o_tdata   = '0;
      o_tuser   = '0;
      o_tlast   = 1'b0;
      o_tvalid  = 1'b0;
      ready_sel = 1'b0;
      case (state_q)
         ST_HI: begin
            o_tdata  = g_data[63:32];
            o_tvalid = g_valid;
            if (g_short) begin
               o_tlast   = 1'b1;
               o_tuser   = g_user[1:0];
               ready_sel = o_tready;
            end
         end
         ST_LO: begin
            o_tdata   = g_data[31:0];
            o_tvalid  = g_valid;
            ready_sel = o_tready;
            o_tlast   = g_last;
            o_tuser   = g_last ? g_user[1:0] : 2'd0;
         end
         default: ;
      endcase
   end

   assign hs       = o_tvalid & o_tready;
   assign last_acc = hs & o_tlast;
   assign rr_ptr_d = (grant_q == SW'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
   assign o_src    = grant_q;

   always_ff @(posedge clk) begin
      if (reset | clear) begin
         state_q  <= ST_IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (any_valid) begin
                  grant_q <= grant_d;
                  state_q <= ST_HI;
               end
            end
            ST_HI: begin
               if (hs) state_q <= g_short ? ST_IDLE : ST_LO;
            end
            ST_LO: begin
               if (hs) state_q <= g_last ? ST_IDLE : ST_HI;
            end
            default: state_q <= ST_IDLE;
         endcase
         if (last_acc) rr_ptr_q <= rr_ptr_d;
      end
   end

`ifdef AXI_ARB_PKT_CNT_EN
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_cnt
         logic [15:0] cnt_q;
         always_ff @(posedge clk) begin
            if (reset | clear)                         cnt_q <= '0;
            else if (last_acc && grant_q == SW'(gi))   cnt_q <= cnt_q + 16'd1;
         end
         assign pkt_cnt[16*gi +: 16] = cnt_q;
      end
   endgenerate
`endif

endmodule
